// File: rtl/sdp_rd_pkg.sv
// Shared types for the sdp_256_8 port-B reader: default widths and FSM state encoding.
package sdp_rd_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/sdp_rd_skid_fifo.sv
// Small skid FIFO holding read data plus its last flag; head is presented combinationally.
module sdp_rd_skid_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 9,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/sdp_256_8_reader.sv
// Port-B read controller for sdp_256_8: streams a run of consecutive bytes as valid/ready/last.
//  state | meaning
//  IDLE  | waiting for start
//  RUN   | issuing reads while the skid FIFO has room
//  DRAIN | all reads issued, waiting for the last byte to be taken
//  DONE  | one-cycle done pulse, then back to IDLE
module sdp_256_8_reader
    import sdp_rd_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SKID_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len_m1,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_adb,
    output logic              ram_ceb,
    output logic              ram_oce,
    output logic              ram_resetb,
    output logic              ram_wreb,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready
);

    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    rd_state_t         r_state;
    rd_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_issue_cnt;
    logic [ADDR_W-1:0] r_out_cnt;
    logic              r_inflight;
    logic              r_inflight_last;

    logic              w_pop;
    logic              w_room;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_last_pop;
    logic              w_clr;
    logic              w_fifo_valid;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [DATA_W:0]   w_fifo_head;

    assign w_pop = w_fifo_valid && m_ready;

    // Occupancy after this cycle (FIFO + in-flight read - pop) must stay below depth to issue.
    assign w_room = ({1'b0, w_fifo_count} + (CNT_W+1)'(r_inflight))
                  < ((CNT_W+1)'(SKID_DEPTH) + (CNT_W+1)'(w_pop));

    assign w_issue      = (r_state == RUN) && !abort && w_room;
    assign w_last_issue = w_issue && (r_issue_cnt == '0);
    assign w_last_pop   = w_pop && (r_out_cnt == '0);
    assign w_clr        = abort && ((r_state == RUN) || (r_state == DRAIN));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN: begin
                if (abort)             w_state_nxt = DONE;
                else if (w_last_issue) w_state_nxt = DRAIN;
            end
            DRAIN:   if (abort || w_last_pop) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_rd_addr       <= '0;
            r_issue_cnt     <= '0;
            r_out_cnt       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && start) begin
                r_rd_addr   <= base_addr;
                r_issue_cnt <= len_m1;
                r_out_cnt   <= len_m1;
            end else begin
                if (w_issue) begin
                    r_rd_addr   <= r_rd_addr + 1'b1;
                    r_issue_cnt <= r_issue_cnt - 1'b1;
                end
                if (w_pop && !w_clr) r_out_cnt <= r_out_cnt - 1'b1;
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_last_issue;
        end
    end

    // Clear wins over the push of a byte still returning from the RAM.
    sdp_rd_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_clr),
        .i_push  (r_inflight),
        .i_data  ({r_inflight_last, ram_dout}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign m_data     = w_fifo_head[DATA_W-1:0];
    assign m_valid    = w_fifo_valid;
    assign m_last     = w_fifo_valid && w_fifo_head[DATA_W];
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign ram_adb    = r_rd_addr;
    assign ram_ceb    = w_issue;
    assign ram_oce    = 1'b1;
    assign ram_wreb   = 1'b0;
    assign ram_resetb = reset;

endmodule

// File: tb/tb_sdp_256_8_reader.sv
// Directed bench for sdp_256_8_reader with a behavioural one-cycle-latency RAM (RAM[i]=i).
module tb_sdp_256_8_reader;

    logic       clk = 1'b0;
    logic       reset, start, abort, m_ready;
    logic [7:0] base_addr, len_m1, ram_adb, m_data;
    logic [7:0] ram_dout = 8'h00;
    logic       busy, done, ram_ceb, ram_oce, ram_resetb, ram_wreb, m_valid, m_last;

    logic [7:0] ram [256];
    int         n_vec = 0, n_miss = 0;
    int         cyc = 0, n_done = 0, rd_out = 0, max_out = 0, stab_err = 0;
    int         rdy_mode = 0;
    logic [7:0] rx_d [$];
    logic       rx_l [$];
    int         rx_c [$];
    logic       p_hold = 1'b0;
    logic [7:0] p_data;
    logic       p_last;

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_ceb) ram_dout <= ram[ram_adb];

    sdp_256_8_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .len_m1     (len_m1),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .ram_adb    (ram_adb),
        .ram_ceb    (ram_ceb),
        .ram_oce    (ram_oce),
        .ram_resetb (ram_resetb),
        .ram_wreb   (ram_wreb),
        .ram_dout   (ram_dout),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready)
    );

    // m_ready changes at negedge; handshakes are recorded for the following posedge.
    always @(negedge clk) begin
        cyc++;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 1) == 1);
            default: m_ready = 1'b0;
        endcase
        #1;
        if (reset) begin
            p_hold = 1'b0;
        end else begin
            if (p_hold && !(m_valid && m_data == p_data && m_last == p_last)) stab_err++;
            p_hold = m_valid && !m_ready && !abort;
            p_data = m_data;
            p_last = m_last;
            if (ram_ceb) rd_out++;
            if (m_valid && m_ready) begin
                rx_d.push_back(m_data);
                rx_l.push_back(m_last);
                rx_c.push_back(cyc);
                rd_out--;
            end
            if (rd_out > max_out) max_out = rd_out;
            if (done) n_done++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx_d.delete();
        rx_l.delete();
        rx_c.delete();
        rd_out   = 0;
        max_out  = 0;
        stab_err = 0;
    endtask

    task automatic pulse_start(input logic [7:0] b, input logic [7:0] l);
        start     = 1'b1;
        base_addr = b;
        len_m1    = l;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input int n0);
        for (int i = 0; i < budget; i++) begin
            if (n_done > n0) break;
            tick();
        end
        chk({tag, "_timeout"}, 32'(n_done > n0), 32'd1);
    endtask

    task automatic check_stream(input string tag, input logic [7:0] b, input int l);
        int         bad = 0;
        int         lbad = 0;
        logic [7:0] e;
        chk({tag, "_len"}, rx_d.size(), l + 1);
        for (int i = 0; i < rx_d.size(); i++) begin
            e = b + 8'(i);
            if (rx_d[i] !== ram[e]) bad++;
            if (rx_l[i] !== (i == l)) lbad++;
        end
        chk({tag, "_data"}, bad, 0);
        chk({tag, "_last"}, lbad, 0);
        chk({tag, "_outst"}, 32'(max_out <= 2), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int bad;
        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
        reset = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; len_m1 = '0;
        m_ready = 1'b0;
        tick(); tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("rst_ceb", ram_ceb, 0);
        chk("rst_adb", ram_adb, 0);
        chk("rst_ties", {ram_oce, ram_wreb, ram_resetb}, 3'b101);
        reset = 1'b0;
        tick();

        // T1 basic run with latency check
        clear_rx(); n0 = n_done;
        pulse_start(8'h10, 8'd3);
        chk("t1_busy", busy, 1);
        chk("t1_ceb", ram_ceb, 1);
        chk("t1_adb", ram_adb, 8'h10);
        tick();
        tick();
        chk("t1_lat_valid", m_valid, 1);
        chk("t1_lat_data", m_data, 8'h10);
        wait_done("t1", 50, n0);
        tick(); tick(); tick();
        chk("t1_done_once", n_done - n0, 1);
        chk("t1_busy_end", busy, 0);
        check_stream("t1", 8'h10, 3);
        chk("t1_consec", (rx_c.size() >= 4) ? rx_c[3] - rx_c[0] : -1, 3);

        // T2 address wrap
        clear_rx(); n0 = n_done;
        pulse_start(8'hFE, 8'd3);
        wait_done("t2", 50, n0);
        check_stream("t2", 8'hFE, 3);

        // T3 random back-pressure
        clear_rx(); n0 = n_done;
        rdy_mode = 1;
        pulse_start(8'h55, 8'd7);
        wait_done("t3", 300, n0);
        rdy_mode = 0;
        check_stream("t3", 8'h55, 7);
        chk("t3_stable", stab_err, 0);
        chk("t3_done_once", n_done - n0, 1);

        // T4 full 256-byte run
        clear_rx(); n0 = n_done;
        pulse_start(8'h00, 8'd255);
        wait_done("t4", 400, n0);
        tick(); tick();
        check_stream("t4", 8'h00, 255);
        chk("t4_thru", (rx_c.size() == 256) ? rx_c[255] - rx_c[0] : -1, 255);
        chk("t4_done_once", n_done - n0, 1);

        // T5 abort after three transfers
        clear_rx(); n0 = n_done;
        pulse_start(8'h30, 8'd15);
        for (int i = 0; i < 50; i++) begin
            if (rx_d.size() >= 3) break;
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_valid_drop", m_valid, 0);
        chk("t5_done", done, 1);
        chk("t5_ceb", ram_ceb, 0);
        tick();
        chk("t5_done_end", done, 0);
        chk("t5_busy", busy, 0);
        chk("t5_rx_cnt", rx_d.size(), 4);
        bad = 0;
        for (int i = 0; i < rx_d.size(); i++)
            if (rx_d[i] !== 8'(8'h30 + i) || rx_l[i] !== 1'b0) bad++;
        chk("t5_rx_data", bad, 0);
        chk("t5_done_once", n_done - n0, 1);
        clear_rx(); n0 = n_done;
        pulse_start(8'h70, 8'd2);
        wait_done("t5b", 50, n0);
        check_stream("t5b", 8'h70, 2);

        // T6 start while busy is ignored
        clear_rx(); n0 = n_done;
        pulse_start(8'h40, 8'd15);
        tick(); tick(); tick();
        start = 1'b1; base_addr = 8'h80; len_m1 = 8'd0;
        tick();
        start = 1'b0;
        wait_done("t6", 100, n0);
        tick(); tick(); tick();
        check_stream("t6", 8'h40, 15);
        chk("t6_done_once", n_done - n0, 1);

        // T6 async reset mid-run
        clear_rx(); n0 = n_done;
        pulse_start(8'h20, 8'd15);
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        #1;
        chk("t6r_busy", busy, 0);
        chk("t6r_valid", m_valid, 0);
        chk("t6r_data", m_data, 0);
        chk("t6r_last", m_last, 0);
        chk("t6r_ceb", ram_ceb, 0);
        chk("t6r_adb", ram_adb, 0);
        chk("t6r_done", done, 0);
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t6r_no_done", n_done - n0, 0);
        chk("t6r_idle", {busy, m_valid}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
